// File: rtl/sal_fifo_pkg.sv
// Shared defaults for the SAL FIFO controller slice.
package sal_fifo_pkg;

    localparam int    DEPTH_LG2_DEF  = 4;
    localparam int    DATA_WIDTH_DEF = 32;
    localparam string RW_SYNC_DEF    = "WR_FIRST";

endpackage

// File: rtl/sal_sdp_ram.sv
// Simple dual-port RAM: port A writes, port B reads, optional registered read data.
module sal_sdp_ram #(
    parameter int    ADDR_W       = 4,
    parameter int    DATA_W       = 32,
    parameter bit    RDATA_FF_OUT = 1'b1,
    parameter string RW_SYNC      = "WR_FIRST"
) (
    input  logic              clk,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              en_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam bit WR_FIRST_C = (RW_SYNC == "WR_FIRST");

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              wr_bypass_s;

    assign wr_bypass_s = en_a & we_a & (addr_a == addr_b) & WR_FIRST_C;

    // Port A write; storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en_a && we_a) begin
            mem_q[addr_a] <= wdata_a;
        end
    end

    generate
        if (RDATA_FF_OUT) begin : g_rd_ff
            logic [DATA_W-1:0] rdata_q;

            // Port B read register, holds while en_b is low.
            always_ff @(posedge clk) begin
                if (en_b) begin
                    rdata_q <= wr_bypass_s ? wdata_a : mem_q[addr_b];
                end
            end

            assign rdata_b = rdata_q;
        end else begin : g_rd_comb
            assign rdata_b = mem_q[addr_b];
        end
    endgenerate

endmodule

// File: rtl/sal_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a registered-output SDP RAM.
// Optional high-water-mark tracking is built when SAL_FIFO_CTRL_HWM_EN is defined.
module sal_fifo_ctrl
    import sal_fifo_pkg::*;
#(
    parameter int DEPTH_LG2  = DEPTH_LG2_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [DATA_WIDTH-1:0]  s_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [DATA_WIDTH-1:0]  m_data_o,
    output logic [DEPTH_LG2+1:0]   count_o,
    input  logic                   hwm_clr_i,
    output logic [DEPTH_LG2+1:0]   hwm_o
);

    localparam int PTR_W = DEPTH_LG2;
    localparam int CNT_W = DEPTH_LG2 + 1;
    localparam int OCC_W = DEPTH_LG2 + 2;
    localparam logic [CNT_W-1:0] RAM_ENTRIES = CNT_W'(2**DEPTH_LG2);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
    logic             m_valid_q, m_valid_d;
    logic             push_s, read_s, pop_s;
    logic [OCC_W-1:0] count_s;

    assign s_ready_o = (ram_cnt_q < RAM_ENTRIES) & ~flush_i;
    assign push_s    = s_valid_i & s_ready_o;
    assign pop_s     = m_valid_q & m_ready_i;
    // An empty RAM never reads, so a word written this cycle is fetched next cycle.
    assign read_s    = (ram_cnt_q != {CNT_W{1'b0}}) & (~m_valid_q | m_ready_i) & ~flush_i;

    // Next-state for pointers, RAM occupancy and the output-stage valid.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        m_valid_d = m_valid_q;
        if (flush_i) begin
            wr_ptr_d  = {PTR_W{1'b0}};
            rd_ptr_d  = {PTR_W{1'b0}};
            ram_cnt_d = {CNT_W{1'b0}};
            m_valid_d = 1'b0;
        end else begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(push_s);
            rd_ptr_d  = rd_ptr_q + PTR_W'(read_s);
            ram_cnt_d = ram_cnt_q + CNT_W'(push_s) - CNT_W'(read_s);
            if (read_s) begin
                m_valid_d = 1'b1;
            end else if (pop_s) begin
                m_valid_d = 1'b0;
            end else begin
                m_valid_d = m_valid_q;
            end
        end
    end

    // Control state registers; reset also drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            ram_cnt_q <= {CNT_W{1'b0}};
            m_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign count_s   = OCC_W'(ram_cnt_q) + OCC_W'(m_valid_q);
    assign count_o   = count_s;
    assign m_valid_o = m_valid_q;

    sal_sdp_ram #(
        .ADDR_W       (PTR_W),
        .DATA_W       (DATA_WIDTH),
        .RDATA_FF_OUT (1'b1),
        .RW_SYNC      ("WR_FIRST")
    ) u_ram (
        .clk     (clk),
        .en_a    (push_s),
        .we_a    (push_s),
        .addr_a  (wr_ptr_q),
        .wdata_a (s_data_i),
        .en_b    (read_s),
        .addr_b  (rd_ptr_q),
        .rdata_b (m_data_o)
    );

`ifdef SAL_FIFO_CTRL_HWM_EN
    logic [OCC_W-1:0] hwm_q, hwm_d;

    // Peak tracking; a clear restarts the peak from the current occupancy.
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr_i) begin
            hwm_d = count_s;
        end else if (count_s > hwm_q) begin
            hwm_d = count_s;
        end else begin
            hwm_d = hwm_q;
        end
    end

    // High-water-mark register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= {OCC_W{1'b0}};
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`else
    logic unused_hwm_clr_s;

    assign unused_hwm_clr_s = hwm_clr_i;
    assign hwm_o            = {OCC_W{1'b0}};
`endif

endmodule
